// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: drives regfile reads, resolves operands through EX/MEM/WB
// forwarding, detects load-use hazards and holds the ID/EX pipeline register.
module id_ex_stage #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_id_valid,
  input  logic [AW-1:0] i_id_rs1,
  input  logic [AW-1:0] i_id_rs2,
  input  logic [AW-1:0] i_id_rd,
  input  logic          i_id_use_rs1,
  input  logic          i_id_use_rs2,
  input  logic          i_id_rd_wr,
  input  logic          i_id_is_load,
  input  logic [CW-1:0] i_id_ctrl,
  output logic [AW-1:0] o_rf_rs1,
  output logic [AW-1:0] o_rf_rs2,
  input  logic [DW-1:0] i_rf_rs1_data,
  input  logic [DW-1:0] i_rf_rs2_data,
  input  logic [DW-1:0] i_ex_fwd_result,
  input  logic          i_exm_valid,
  input  logic          i_exm_rd_wr,
  input  logic          i_exm_is_load,
  input  logic [AW-1:0] i_exm_rd,
  input  logic [DW-1:0] i_exm_result,
  input  logic          i_wb_rf_wr,
  input  logic [AW-1:0] i_wb_rd,
  input  logic [DW-1:0] i_wb_wdata,
  input  logic          i_flush,
  input  logic          i_ex_stall,
  output logic          o_id_stall,
  output logic          o_id_rs1_neg,
  output logic          o_ex_valid,
  output logic          o_ex_rd_wr,
  output logic          o_ex_is_load,
  output logic [AW-1:0] o_ex_rd,
  output logic [DW-1:0] o_ex_rs1_val,
  output logic [DW-1:0] o_ex_rs2_val,
  output logic [CW-1:0] o_ex_ctrl,
  output logic [15:0]   o_stall_cnt
);

  logic          r_ex_valid;
  logic          r_ex_rd_wr;
  logic          r_ex_is_load;
  logic [AW-1:0] r_ex_rd;
  logic [DW-1:0] r_ex_rs1_val;
  logic [DW-1:0] r_ex_rs2_val;
  logic [CW-1:0] r_ex_ctrl;
  logic [15:0]   r_stall_cnt;

  logic          w_ex_fwd_en;
  logic          w_exm_fwd_en;
  logic          w_ex_ld;
  logic          w_exm_ld;
  logic          w_hazard;
  logic [DW-1:0] w_rs1_fwd;
  logic [DW-1:0] w_rs2_fwd;

  function automatic logic src_match(input logic use_s, input logic [AW-1:0] s,
                                     input logic [AW-1:0] d);
    return use_s && (s == d);
  endfunction

  assign o_rf_rs1     = i_id_rs1;
  assign o_rf_rs2     = i_id_rs2;
  assign w_ex_fwd_en  = r_ex_valid & r_ex_rd_wr & ~r_ex_is_load;
  assign w_exm_fwd_en = i_exm_valid & i_exm_rd_wr & ~i_exm_is_load;
  assign w_ex_ld      = r_ex_valid & r_ex_is_load & r_ex_rd_wr;
  assign w_exm_ld     = i_exm_valid & i_exm_is_load & i_exm_rd_wr;

  // A load result is not available until after MEM, so any consumer in its shadow must wait.
  assign w_hazard = i_id_valid &
      ((w_ex_ld & (src_match(i_id_use_rs1, i_id_rs1, r_ex_rd) |
                   src_match(i_id_use_rs2, i_id_rs2, r_ex_rd))) |
       (w_exm_ld & (src_match(i_id_use_rs1, i_id_rs1, i_exm_rd) |
                    src_match(i_id_use_rs2, i_id_rs2, i_exm_rd))));

  assign o_id_stall   = w_hazard | i_ex_stall;
  assign o_id_rs1_neg = w_rs1_fwd[DW-1];

  always_comb begin
    w_rs1_fwd = i_rf_rs1_data;
    if (w_ex_fwd_en && src_match(i_id_use_rs1, i_id_rs1, r_ex_rd)) begin
      w_rs1_fwd = i_ex_fwd_result;
    end else if (w_exm_fwd_en && src_match(i_id_use_rs1, i_id_rs1, i_exm_rd)) begin
      w_rs1_fwd = i_exm_result;
    end else if (i_wb_rf_wr && src_match(i_id_use_rs1, i_id_rs1, i_wb_rd)) begin
      w_rs1_fwd = i_wb_wdata;
    end else begin
      w_rs1_fwd = i_rf_rs1_data;
    end
  end

  always_comb begin
    w_rs2_fwd = i_rf_rs2_data;
    if (w_ex_fwd_en && src_match(i_id_use_rs2, i_id_rs2, r_ex_rd)) begin
      w_rs2_fwd = i_ex_fwd_result;
    end else if (w_exm_fwd_en && src_match(i_id_use_rs2, i_id_rs2, i_exm_rd)) begin
      w_rs2_fwd = i_exm_result;
    end else if (i_wb_rf_wr && src_match(i_id_use_rs2, i_id_rs2, i_wb_rd)) begin
      w_rs2_fwd = i_wb_wdata;
    end else begin
      w_rs2_fwd = i_rf_rs2_data;
    end
  end

  // Payload is left untouched on flush/bubble; only the qualifiers are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_wr   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_rd      <= {AW{1'b0}};
      r_ex_rs1_val <= {DW{1'b0}};
      r_ex_rs2_val <= {DW{1'b0}};
      r_ex_ctrl    <= {CW{1'b0}};
    end else if (i_flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_wr   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (i_ex_stall) begin
      r_ex_valid   <= r_ex_valid;
      r_ex_rd_wr   <= r_ex_rd_wr;
      r_ex_is_load <= r_ex_is_load;
    end else if (w_hazard) begin
      r_ex_valid   <= 1'b0;
      r_ex_rd_wr   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else begin
      r_ex_valid   <= i_id_valid;
      r_ex_rd_wr   <= i_id_valid & i_id_rd_wr;
      r_ex_is_load <= i_id_valid & i_id_is_load;
      r_ex_rd      <= i_id_rd;
      r_ex_rs1_val <= w_rs1_fwd;
      r_ex_rs2_val <= w_rs2_fwd;
      r_ex_ctrl    <= i_id_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
    end else if (w_hazard && !i_flush && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign o_ex_valid   = r_ex_valid;
  assign o_ex_rd_wr   = r_ex_rd_wr;
  assign o_ex_is_load = r_ex_is_load;
  assign o_ex_rd      = r_ex_rd;
  assign o_ex_rs1_val = r_ex_rs1_val;
  assign o_ex_rs2_val = r_ex_rs2_val;
  assign o_ex_ctrl    = r_ex_ctrl;
  assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural pipeline model predicts each ID/EX
// register state, a monitor compares after every clock edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_use_rs1, id_use_rs2, id_rd_wr, id_is_load;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic [3:0]  rf_rs1, rf_rs2;
  logic [15:0] rf_rs1_data, rf_rs2_data, ex_fwd_result;
  logic        exm_valid, exm_rd_wr, exm_is_load;
  logic [3:0]  exm_rd;
  logic [15:0] exm_result;
  logic        wb_rf_wr;
  logic [3:0]  wb_rd;
  logic [15:0] wb_wdata;
  logic        flush, ex_stall;
  logic        id_stall, id_rs1_neg;
  logic        ex_valid, ex_rd_wr, ex_is_load;
  logic [3:0]  ex_rd;
  logic [15:0] ex_rs1_val, ex_rs2_val;
  logic [7:0]  ex_ctrl;
  logic [15:0] stall_cnt;

  typedef struct {
    logic valid, use1, use2, rd_wr, is_load;
    logic [3:0] rs1, rs2, rd;
    logic [7:0] ctrl;
    logic [15:0] rf1, rf2, exfwd;
    logic exm_valid, exm_rd_wr, exm_is_load;
    logic [3:0] exm_rd;
    logic [15:0] exm_result;
    logic wb_wr;
    logic [3:0] wb_rd;
    logic [15:0] wb_wdata;
    logic flush, ex_stall;
  } stim_t;

  typedef struct {
    logic valid, rd_wr, is_load;
    logic [3:0] rd;
    logic [15:0] v1, v2;
    logic [7:0] ctrl;
    logic [15:0] cnt;
  } mdl_t;

  mdl_t m;
  mdl_t q[$];
  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DW(16), .AW(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd),
    .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2), .i_id_rd_wr(id_rd_wr),
    .i_id_is_load(id_is_load), .i_id_ctrl(id_ctrl),
    .o_rf_rs1(rf_rs1), .o_rf_rs2(rf_rs2),
    .i_rf_rs1_data(rf_rs1_data), .i_rf_rs2_data(rf_rs2_data),
    .i_ex_fwd_result(ex_fwd_result),
    .i_exm_valid(exm_valid), .i_exm_rd_wr(exm_rd_wr), .i_exm_is_load(exm_is_load),
    .i_exm_rd(exm_rd), .i_exm_result(exm_result),
    .i_wb_rf_wr(wb_rf_wr), .i_wb_rd(wb_rd), .i_wb_wdata(wb_wdata),
    .i_flush(flush), .i_ex_stall(ex_stall),
    .o_id_stall(id_stall), .o_id_rs1_neg(id_rs1_neg),
    .o_ex_valid(ex_valid), .o_ex_rd_wr(ex_rd_wr), .o_ex_is_load(ex_is_load),
    .o_ex_rd(ex_rd), .o_ex_rs1_val(ex_rs1_val), .o_ex_rs2_val(ex_rs2_val),
    .o_ex_ctrl(ex_ctrl), .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.valid = ($urandom_range(0, 7) != 0);
    s.use1 = $urandom_range(0, 1); s.use2 = $urandom_range(0, 1);
    s.rd_wr = $urandom_range(0, 1); s.is_load = ($urandom_range(0, 3) == 0);
    s.rs1 = 4'($urandom_range(0, 3)); s.rs2 = 4'($urandom_range(0, 3));
    s.rd = 4'($urandom_range(0, 3)); s.ctrl = 8'($urandom);
    s.rf1 = 16'($urandom); s.rf2 = 16'($urandom); s.exfwd = 16'($urandom);
    s.exm_valid = $urandom_range(0, 1); s.exm_rd_wr = $urandom_range(0, 1);
    s.exm_is_load = ($urandom_range(0, 3) == 0); s.exm_rd = 4'($urandom_range(0, 3));
    s.exm_result = 16'($urandom);
    s.wb_wr = $urandom_range(0, 1); s.wb_rd = 4'($urandom_range(0, 3));
    s.wb_wdata = 16'($urandom);
    s.flush = ($urandom_range(0, 15) == 0); s.ex_stall = ($urandom_range(0, 4) == 0);
    return s;
  endfunction

  // Reference: start from the regfile value and let each older-to-younger producer override it.
  function automatic logic [15:0] resolve(input logic use_s, input logic [3:0] s,
                                          input logic [15:0] rf, input stim_t st);
    logic [15:0] v;
    v = rf;
    if (use_s && st.wb_wr && st.wb_rd == s) v = st.wb_wdata;
    if (use_s && st.exm_valid && st.exm_rd_wr && !st.exm_is_load && st.exm_rd == s)
      v = st.exm_result;
    if (use_s && m.valid && m.rd_wr && !m.is_load && m.rd == s) v = st.exfwd;
    return v;
  endfunction

  function automatic logic reads(input stim_t st, input logic [3:0] d);
    return (st.use1 && st.rs1 == d) || (st.use2 && st.rs2 == d);
  endfunction

  function automatic logic hazard_of(input stim_t st);
    logic ld_in_ex, ld_in_mem;
    ld_in_ex  = m.valid && m.is_load && m.rd_wr && reads(st, m.rd);
    ld_in_mem = st.exm_valid && st.exm_is_load && st.exm_rd_wr && reads(st, st.exm_rd);
    return st.valid && (ld_in_ex || ld_in_mem);
  endfunction

  task automatic apply(input stim_t s);
    id_valid = s.valid; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    id_rd_wr = s.rd_wr; id_is_load = s.is_load;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_ctrl = s.ctrl;
    rf_rs1_data = s.rf1; rf_rs2_data = s.rf2; ex_fwd_result = s.exfwd;
    exm_valid = s.exm_valid; exm_rd_wr = s.exm_rd_wr; exm_is_load = s.exm_is_load;
    exm_rd = s.exm_rd; exm_result = s.exm_result;
    wb_rf_wr = s.wb_wr; wb_rd = s.wb_rd; wb_wdata = s.wb_wdata;
    flush = s.flush; ex_stall = s.ex_stall;
  endtask

  task automatic cycle(input stim_t s);
    mdl_t n;
    logic hz;
    logic [15:0] f1, f2;
    @(negedge clk);
    apply(s);
    #1;
    hz = hazard_of(s);
    f1 = resolve(s.use1, s.rs1, s.rf1, s);
    f2 = resolve(s.use2, s.rs2, s.rf2, s);
    chk("rf_rs1", 32'(rf_rs1), 32'(s.rs1));
    chk("rf_rs2", 32'(rf_rs2), 32'(s.rs2));
    chk("id_stall", 32'(id_stall), 32'(hz | s.ex_stall));
    chk("id_rs1_neg", 32'(id_rs1_neg), 32'(f1[15]));
    n = m;
    if (s.flush) begin
      n.valid = 1'b0; n.rd_wr = 1'b0; n.is_load = 1'b0;
    end else if (s.ex_stall) begin
      n = m;
    end else if (hz) begin
      n.valid = 1'b0; n.rd_wr = 1'b0; n.is_load = 1'b0;
    end else begin
      n.valid = s.valid; n.rd_wr = s.valid & s.rd_wr; n.is_load = s.valid & s.is_load;
      n.rd = s.rd; n.v1 = f1; n.v2 = f2; n.ctrl = s.ctrl;
    end
    if (hz && !s.flush && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
    q.push_back(n);
    m = n;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_rd_wr", 32'(ex_rd_wr), 32'd0);
    chk("rst_ex_is_load", 32'(ex_is_load), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_ex_rs1_val", 32'(ex_rs1_val), 32'd0);
    chk("rst_ex_rs2_val", 32'(ex_rs2_val), 32'd0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    q.delete();
    m = '{default: '0};
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare the DUT's ID/EX state to the oldest prediction after each edge.
  always begin
    mdl_t e;
    @(posedge clk);
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("sb_ex_rd_wr", 32'(ex_rd_wr), 32'(e.rd_wr));
      chk("sb_ex_is_load", 32'(ex_is_load), 32'(e.is_load));
      chk("sb_stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      chk("sb_payload_known", 32'($isunknown({ex_rd, ex_rs1_val, ex_rs2_val, ex_ctrl})), 32'd0);
      if (e.valid) begin
        chk("sb_ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("sb_ex_rs1_val", 32'(ex_rs1_val), 32'(e.v1));
        chk("sb_ex_rs2_val", 32'(ex_rs2_val), 32'(e.v2));
        chk("sb_ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
      end
    end
  end

  initial begin
    stim_t s;
    m = '{default: '0};
    apply(idle());
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset while an instruction occupies EX
    s = idle(); s.valid = 1'b1; s.rd_wr = 1'b1; s.rd = 4'd6; s.ctrl = 8'h77; s.rf1 = 16'h5555;
    cycle(s);
    after_edge();
    chk("pre_rst_ex_valid", 32'(ex_valid), 32'd1);
    do_reset();

    // EX forwarding
    s = idle(); s.valid = 1'b1; s.rd = 4'd3; s.rd_wr = 1'b1;
    cycle(s);
    s = idle(); s.valid = 1'b1; s.use1 = 1'b1; s.rs1 = 4'd3; s.rf1 = 16'h0000; s.exfwd = 16'h1234;
    cycle(s);
    chk("t2_id_stall", 32'(id_stall), 32'd0);
    after_edge();
    chk("t2_ex_rs1_val", 32'(ex_rs1_val), 32'h1234);

    // forwarding priority
    s = idle(); s.valid = 1'b1; s.rd = 4'd5; s.rd_wr = 1'b1;
    cycle(s);
    s = idle(); s.valid = 1'b1; s.use1 = 1'b1; s.rs1 = 4'd5; s.exfwd = 16'hAAAA;
    s.exm_valid = 1'b1; s.exm_rd_wr = 1'b1; s.exm_rd = 4'd5; s.exm_result = 16'hBBBB;
    s.wb_wr = 1'b1; s.wb_rd = 4'd5; s.wb_wdata = 16'hCCCC; s.rf1 = 16'h0101;
    cycle(s);
    after_edge();
    chk("t3_ex_prio", 32'(ex_rs1_val), 32'hAAAA);
    s.exfwd = 16'h1111;
    cycle(s);
    after_edge();
    chk("t3_mem_prio", 32'(ex_rs1_val), 32'hBBBB);
    s.exm_valid = 1'b0;
    cycle(s);
    after_edge();
    chk("t3_wb_only", 32'(ex_rs1_val), 32'hCCCC);

    // load-use: two bubbles, then WB forwarding
    do_reset();
    s = idle(); s.valid = 1'b1; s.rd = 4'd2; s.rd_wr = 1'b1; s.is_load = 1'b1;
    cycle(s);
    s = idle(); s.valid = 1'b1; s.use2 = 1'b1; s.rs2 = 4'd2; s.rd = 4'd8; s.rd_wr = 1'b1;
    cycle(s);
    chk("t4_stall_1", 32'(id_stall), 32'd1);
    after_edge();
    chk("t4_bubble_1", 32'(ex_valid), 32'd0);
    s.exm_valid = 1'b1; s.exm_rd_wr = 1'b1; s.exm_is_load = 1'b1; s.exm_rd = 4'd2;
    cycle(s);
    chk("t4_stall_2", 32'(id_stall), 32'd1);
    after_edge();
    chk("t4_bubble_2", 32'(ex_valid), 32'd0);
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd2);
    s.exm_valid = 1'b0; s.exm_is_load = 1'b0;
    s.wb_wr = 1'b1; s.wb_rd = 4'd2; s.wb_wdata = 16'h00F0; s.rf2 = 16'h0000;
    cycle(s);
    chk("t4_no_stall", 32'(id_stall), 32'd0);
    after_edge();
    chk("t4_issue_valid", 32'(ex_valid), 32'd1);
    chk("t4_ex_rs2_val", 32'(ex_rs2_val), 32'h00F0);

    // flush beats stall; stall holds
    s = idle(); s.valid = 1'b1; s.rd = 4'd7; s.rd_wr = 1'b1;
    cycle(s);
    s.flush = 1'b1; s.ex_stall = 1'b1;
    cycle(s);
    after_edge();
    chk("t5_flush_valid", 32'(ex_valid), 32'd0);
    s = idle(); s.valid = 1'b1; s.rd = 4'd9; s.rd_wr = 1'b1; s.ctrl = 8'hC3;
    s.rf1 = 16'h3333; s.rf2 = 16'h4444;
    cycle(s);
    s = idle(); s.valid = 1'b1; s.rd = 4'd1; s.ctrl = 8'h00; s.rf1 = 16'hFFFF; s.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(s);
      after_edge();
      chk("t5_hold_valid", 32'(ex_valid), 32'd1);
      chk("t5_hold_rd", 32'(ex_rd), 32'd9);
      chk("t5_hold_rs1", 32'(ex_rs1_val), 32'h3333);
      chk("t5_hold_rs2", 32'(ex_rs2_val), 32'h4444);
      chk("t5_hold_ctrl", 32'(ex_ctrl), 32'hC3);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) cycle(rnd());

    // counter saturation
    do_reset();
    s = idle(); s.valid = 1'b1; s.use1 = 1'b1; s.rs1 = 4'd1;
    s.exm_valid = 1'b1; s.exm_rd_wr = 1'b1; s.exm_is_load = 1'b1; s.exm_rd = 4'd1;
    for (int i = 0; i < 65534; i++) cycle(s);
    after_edge();
    chk("t6_cnt_fffe", 32'(stall_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) cycle(s);
    after_edge();
    chk("t6_cnt_sat", 32'(stall_cnt), 32'hFFFF);

    // sign of forwarded rs1, independent of id_valid
    s = idle(); s.use1 = 1'b1; s.rs1 = 4'd4; s.rf1 = 16'h0001;
    s.exm_valid = 1'b1; s.exm_rd_wr = 1'b1; s.exm_rd = 4'd4; s.exm_result = 16'h8001;
    cycle(s);
    chk("t6_rs1_neg_fwd", 32'(id_rs1_neg), 32'd1);
    s.exm_valid = 1'b0;
    cycle(s);
    chk("t6_rs1_neg_rf", 32'(id_rs1_neg), 32'd0);

    after_edge();
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the register file.
- Drives the register file read addresses and takes in the raw read data.
- Applies operand forwarding from the EX, MEM and WB stages, and detects load-use hazards.
- Registers the resolved operands and control into the ID/EX pipeline register. Also provides stall/flush handling and a saturating hazard-stall counter.

Parameters:
- DW, 16, datapath width.
- AW, 4, register address width (16 registers).
- CW, 8, width of opaque control bundle passed through to EX.

Ports:
- clk in 1: clock; all state updates on posedge.
- rst in 1: asynchronous, active-high reset.
- id_valid in 1: decoded instruction present in ID.
- id_rs1, id_rs2, id_rd in AW: source and destination register numbers.
- id_use_rs1, id_use_rs2 in 1: instruction reads that source.
- id_rd_wr in 1: instruction writes rd.
- id_is_load in 1: instruction is a load.
- id_ctrl in CW: pass-through control.
- rf_rs1, rf_rs2 out AW: regfile read addresses; combinational copies of id_rs1/id_rs2.
- rf_rs1_data, rf_rs2_data in DW: regfile read data, combinational.
- ex_fwd_result in DW: EX-stage ALU result this cycle, combinational from EX.
- exm_valid, exm_rd_wr, exm_is_load in 1: EX/MEM register state.
- exm_rd in AW: EX/MEM register destination.
- exm_result in DW: EX/MEM register ALU result.
- wb_rf_wr in 1, wb_rd in AW, wb_wdata in DW: regfile write port, the same signals that feed the regfile.
- flush in 1: branch-taken kill of the ID/EX register contents.
- ex_stall in 1: downstream stage cannot accept.
- id_stall out 1: hold IF/ID.
- id_rs1_neg out 1: bit DW-1 of forwarded rs1 operand, for the branch-less-than-zero decision.
- ex_valid, ex_rd_wr, ex_is_load out 1: ID/EX register.
- ex_rd out AW; ex_rs1_val, ex_rs2_val out DW; ex_ctrl out CW: ID/EX register.
- stall_cnt out 16: hazard-stall cycle count.

Behaviour:
- Reset (async, rst=1): every registered output goes to 0, including ex_valid, ex_rd_wr, ex_is_load, ex_rd, ex_rs*_val, ex_ctrl and stall_cnt. Reset mid-stall clears the state, and the next cycle after release behaves as a fresh start.
- Match rule: a source s matches destination d when id_use_s=1 and id_s==d. No register is hardwired to zero; R0 forwards like any other register.
- Forwarding, per source, combinational, priority highest first:
  - EX: ex_valid & ex_rd_wr & ~ex_is_load & match(ex_rd) -> ex_fwd_result.
  - MEM: exm_valid & exm_rd_wr & ~exm_is_load & match(exm_rd) -> exm_result.
  - WB: wb_rf_wr & match(wb_rd) -> wb_wdata. This path is required because the regfile write lands on the same edge and is not visible through the read.
  - Otherwise -> rf_*_data.
- Hazard: id_valid & ((ex_valid & ex_is_load & ex_rd_wr & match(ex_rd)) | (exm_valid & exm_is_load & exm_rd_wr & match(exm_rd))). A load feeding the next instruction therefore costs 2 bubbles; a load two instructions ahead costs 1.
- id_stall = hazard | ex_stall, combinational.
- ID/EX register update at posedge, priority highest first:
  - flush: ex_valid, ex_rd_wr, ex_is_load <= 0.
  - ex_stall: hold all fields.
  - hazard: bubble; ex_valid, ex_rd_wr, ex_is_load <= 0.
  - otherwise: load forwarded operands and id_* fields. ex_valid <= id_valid, and ex_rd_wr / ex_is_load are gated by id_valid.
- Latency: 1 cycle from ID to ex_* outputs. Operands are captured at load time, so a held (ex_stall) entry is not re-forwarded.
- Bubble or flushed entries: ex_rd_wr and ex_is_load must be 0. Other payload fields are don't-care but must not be X.
- stall_cnt: +1 on each cycle where hazard=1 and flush=0, saturating at 0xFFFF. Cycles with only ex_stall do not count.
- id_rs1_neg: always reflects the forwarded rs1 value, whether or not id_valid is set.

Test Plan:
1. Reset: assert rst mid-run with ex_valid=1 -> all ex_* outputs and stall_cnt read 0 immediately, before the next clock edge.
2. EX forwarding: ADD r3 then SUB using rs1=r3, ex_fwd_result=0x1234, regfile r3=0x0000 -> ex_rs1_val=0x1234 next cycle, id_stall=0.
3. Priority: r5 matches EX (0xAAAA), MEM (0xBBBB) and WB (0xCCCC) simultaneously -> 0xAAAA. With EX removed -> 0xBBBB. With only WB -> 0xCCCC.
4. Load-use: LD r2 followed by an instruction using rs2=r2 -> id_stall=1 for 2 cycles, 2 bubbles with ex_valid=0, stall_cnt=2. The dependent instruction then issues with ex_rs2_val=wb_wdata=0x00F0.
5. Flush vs stall: flush=1 and ex_stall=1 in the same cycle -> ex_valid=0 next cycle. With ex_stall=1 alone for 3 cycles, the ex_* outputs hold unchanged.
6. Saturation and blz: preload stall_cnt to 0xFFFE, then 3 hazard cycles -> 0xFFFF. Forwarded rs1=0x8001 -> id_rs1_neg=1 while the regfile data is 0x0001.
